hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage datapath.
- Drives the write-enables and bubble/flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves three hazards:
  - load-use stalls;
  - taken branch/jump redirects resolved at the EX/MEM register outputs;
  - data-memory wait states, with a ready handshake and a timeout.
- Keeps saturating stall/flush performance counters.

Parameters:
- MEM_TIMEOUT, 15: maximum cycles spent in MEM_WAIT before ERROR (must be ≥1).
- CNT_W, 16: width of the performance counters.

Ports:
- clkHAZ  in  1  clock; all state updates on rising edge.
- rstHAZ  in  1  asynchronous, active-high reset.
- IFID_rs  in  5  rs of the instruction in decode.
- IFID_rt  in  5  rt of the instruction in decode.
- IDEX_MemRead  in  1  the instruction in EX is a load.
- IDEX_rt  in  5  load destination register in EX.
- EXMEM_Branch  in  1  Branch output of the EX/MEM register.
- EXMEM_ZF  in  1  ZFtAND output of the EX/MEM register.
- EXMEM_jump  in  1  jump_out of the EX/MEM register.
- EXMEM_MemRead  in  1  MEM-stage load.
- EXMEM_MemWrite  in  1  MEM-stage store.
- mem_ready  in  1  data memory completes the current access this cycle.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register write-enables.
- ifid_flush, idex_flush, exmem_flush  out  1 each  load a bubble (all controls 0) instead of data.
- pc_sel  out  1  PC takes the branch/jump target from EX/MEM.
- mem_req  out  1  memory access request.
- state  out  2  RUN=0, MEM_WAIT=1, ERROR=2.
- mem_timeout  out  1  sticky error flag.
- stall_cnt  out  CNT_W  stall cycles.
- flush_cnt  out  CNT_W  taken redirects.

Behaviour:
- Reset (async):
  - state=RUN, timer=0, counters=0, mem_timeout=0.
  - While rstHAZ=1, all enables/flushes/pc_sel/mem_req are 0.
- Derived terms:
  - memop = EXMEM_MemRead | EXMEM_MemWrite.
  - taken = (EXMEM_Branch & EXMEM_ZF) | EXMEM_jump.
  - lu = IDEX_MemRead & IDEX_rt≠0 & (IDEX_rt==IFID_rs | IDEX_rt==IFID_rt).
- mem_req = memop & (state≠ERROR). It stays high until mem_ready is sampled.
- Outputs are Mealy. Priority in RUN, highest first:
  1. memop & !mem_ready:
     - all five enables 0, no flushes;
     - next state MEM_WAIT, timer←MEM_TIMEOUT−1;
     - stall_cnt+1.
  2. taken:
     - all enables 1, pc_sel=1, ifid_flush=idex_flush=exmem_flush=1;
     - flush_cnt+1;
     - any concurrent lu is ignored and is not counted.
  3. lu:
     - pc_en=ifid_en=0, idex_flush=1, exmem_en=memwb_en=1;
     - stall_cnt+1;
     - lasts exactly one cycle, because the bubble clears IDEX_MemRead.
  4. Otherwise all enables 1, no flushes, pc_sel=0.
- MEM_WAIT:
  - mem_ready=1: priority rules 2–4 apply this cycle as in RUN (memory now complete); next state RUN.
  - mem_ready=0 and timer==0: all enables 0; next state ERROR; mem_timeout←1.
  - Otherwise: all enables 0; timer−1; stall_cnt+1.
  - Result: MEM_WAIT lasts at most MEM_TIMEOUT cycles.
- ERROR:
  - all enables, flushes, pc_sel and mem_req are 0; counters frozen;
  - exits only via reset.
- A taken branch is honoured only in a cycle where EX/MEM advances. A redirect held behind a memory stall is applied on release, exactly once.
- Counters saturate at all-ones; no wrap.
- Reset mid-MEM_WAIT returns to RUN immediately; the pending access is abandoned.

Decomposition:
- Shared package pipe_pkg holds:
  - state encoding constants RUN/MEM_WAIT/ERROR;
  - the zero-register index constant;
  - a bubble control-word constant, also used by IF/ID, ID/EX and EX/MEM.
- One sub-module, sat_counter (width CNT_W, inc, async reset), instantiated twice.

Test Plan:
- Load-use: IDEX_MemRead=1, IDEX_rt=8, IFID_rs=8 → one cycle of pc_en=0, ifid_en=0, idex_flush=1; stall_cnt=1. Same stimulus with IDEX_rt=0 → no stall.
- Taken branch: EXMEM_Branch=1, ZF=1 → pc_sel=1 and all three flushes for one cycle; flush_cnt=1. Same with ZF=0 → no flush.
- Memory wait:
  - EXMEM_MemRead=1, mem_ready low 3 cycles then high → enables 0 for 3 cycles; state=1 for 3 cycles; stall_cnt=3; enables 1 on the ready cycle; then RUN.
  - Ready on the first cycle → no stall.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 → state=2 after 1+4 cycles; mem_timeout=1; everything frozen until rstHAZ, which returns RUN and clears mem_timeout and counters.
- Simultaneous events:
  - taken & lu in the same cycle → flush only; stall_cnt unchanged.
  - memop & !mem_ready & EXMEM_jump → freeze first, pc_sel asserted only on the release cycle.
- Saturation: CNT_W=3, 10 load-use stalls → stall_cnt=7. Async reset asserted mid-clock → outputs drop without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: encodings shared by the pipeline registers and the hazard controller
package pipe_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, ERROR = 2'd2} state_t;
  localparam logic [4:0] ZERO_REG = 5'd0;
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic pc_sel;
  } ctrl_t;
  // all-zero control word: a bubble everywhere it is loaded
  localparam ctrl_t BUBBLE = '0;
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: decode/EX/MEM hazard inputs and pipeline register controls
interface hazard_ctrl_if #(parameter int CNT_W = 16);
  logic [4:0] IFID_rs, IFID_rt, IDEX_rt;
  logic IDEX_MemRead, EXMEM_Branch, EXMEM_ZF, EXMEM_jump, EXMEM_MemRead, EXMEM_MemWrite, mem_ready;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, pc_sel, mem_req;
  logic [1:0] state;
  logic mem_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  modport master (
    output IFID_rs, IFID_rt, IDEX_rt, IDEX_MemRead, EXMEM_Branch, EXMEM_ZF, EXMEM_jump,
           EXMEM_MemRead, EXMEM_MemWrite, mem_ready,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush,
           pc_sel, mem_req, state, mem_timeout, stall_cnt, flush_cnt
  );
  modport slave (
    input  IFID_rs, IFID_rt, IDEX_rt, IDEX_MemRead, EXMEM_Branch, EXMEM_ZF, EXMEM_jump,
           EXMEM_MemRead, EXMEM_MemWrite, mem_ready,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush,
           pc_sel, mem_req, state, mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones, async active-high reset
module sat_counter #(parameter int W = 16) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (inc && q != '1) q <= q + 1'b1;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stalls, EX/MEM redirects and data-memory wait/timeout sequencing
module hazard_ctrl import pipe_pkg::*; #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W = 16
) (
  input logic clkHAZ,
  input logic rstHAZ,
  hazard_ctrl_if.slave hz
);
  localparam int TW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;
  localparam ctrl_t RUN_C = 9'b11111_000_0;
  localparam ctrl_t LU_C  = 9'b00111_010_0;
  localparam ctrl_t TKN_C = 9'b11111_111_1;
  state_t st, st_n;
  logic [TW-1:0] tmr, tmr_n;
  logic tmo_q, tmo_n, stall_inc, flush_inc, memop, taken, lu;
  ctrl_t c, run_c, o;
  assign memop = hz.EXMEM_MemRead | hz.EXMEM_MemWrite;
  assign taken = (hz.EXMEM_Branch & hz.EXMEM_ZF) | hz.EXMEM_jump;
  assign lu = hz.IDEX_MemRead && hz.IDEX_rt != ZERO_REG &&
              (hz.IDEX_rt == hz.IFID_rs || hz.IDEX_rt == hz.IFID_rt);
  assign run_c = taken ? TKN_C : lu ? LU_C : RUN_C;
  // a redirect only fires on a cycle where EX/MEM advances, so a held branch is taken once on release
  always_comb begin
    c = BUBBLE;
    st_n = st;
    tmr_n = tmr;
    tmo_n = tmo_q;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (st == RUN && memop && !hz.mem_ready) begin
      st_n = MEM_WAIT;
      tmr_n = TW'(MEM_TIMEOUT - 1);
      stall_inc = 1'b1;
    end else if (st == MEM_WAIT && !hz.mem_ready) begin
      if (tmr == '0) begin
        st_n = ERROR;
        tmo_n = 1'b1;
      end else begin
        tmr_n = tmr - 1'b1;
        stall_inc = 1'b1;
      end
    end else if (st != ERROR) begin
      c = run_c;
      st_n = RUN;
      flush_inc = taken;
      stall_inc = !taken && lu;
    end
  end
  always_ff @(posedge clkHAZ or posedge rstHAZ)
    if (rstHAZ) begin
      st <= RUN;
      tmr <= '0;
      tmo_q <= 1'b0;
    end else begin
      st <= st_n;
      tmr <= tmr_n;
      tmo_q <= tmo_n;
    end
  assign o = rstHAZ ? BUBBLE : c;
  assign {hz.pc_en, hz.ifid_en, hz.idex_en, hz.exmem_en, hz.memwb_en,
          hz.ifid_flush, hz.idex_flush, hz.exmem_flush, hz.pc_sel} = o;
  assign hz.mem_req = !rstHAZ && memop && st != ERROR;
  assign hz.state = st;
  assign hz.mem_timeout = tmo_q;
  sat_counter #(.W(CNT_W)) u_stall (.clk(clkHAZ), .rst(rstHAZ), .inc(stall_inc), .q(hz.stall_cnt));
  sat_counter #(.W(CNT_W)) u_flush (.clk(clkHAZ), .rst(rstHAZ), .inc(flush_inc), .q(hz.flush_cnt));
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: vector table, corner-case sequences and random run against a behavioural model
module tb_hazard_ctrl;
  localparam int TMO = 4, CW = 3, MAXC = (1 << CW) - 1, NT = 15;
  localparam logic [9:0] NRM = 10'b11111_000_0_0, LUC = 10'b00111_010_0_0;
  localparam logic [9:0] TKN = 10'b11111_111_1_0, FRZ = 10'b00000_000_0_0;
  typedef struct packed {logic [4:0] rs, rt, irt; logic imr, br, zf, j, emr, emw, rdy;} vec_t;
  typedef struct {vec_t in; logic [9:0] ctrl; int st, stall, flush;} row_t;
  logic clk = 1'b0, rst = 1'b1;
  int errs = 0, checks = 0;
  int m_mode, m_waited, m_stall, m_flush;
  bit m_to;
  vec_t v;
  row_t tbl [NT];
  always #5 clk = ~clk;
  hazard_ctrl_if #(.CNT_W(CW)) hz();
  hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (.clkHAZ(clk), .rstHAZ(rst), .hz(hz));

  function automatic vec_t mk(int rs, int rt, int irt, int imr, int br, int zf, int j, int emr, int emw, int rdy);
    return {5'(rs), 5'(rt), 5'(irt), 1'(imr), 1'(br), 1'(zf), 1'(j), 1'(emr), 1'(emw), 1'(rdy)};
  endfunction

  function automatic logic [9:0] dut_ctrl();
    return {hz.pc_en, hz.ifid_en, hz.idex_en, hz.exmem_en, hz.memwb_en,
            hz.ifid_flush, hz.idex_flush, hz.exmem_flush, hz.pc_sel, hz.mem_req};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(vec_t x);
    v = x;
    hz.IFID_rs = x.rs; hz.IFID_rt = x.rt; hz.IDEX_rt = x.irt; hz.IDEX_MemRead = x.imr;
    hz.EXMEM_Branch = x.br; hz.EXMEM_ZF = x.zf; hz.EXMEM_jump = x.j;
    hz.EXMEM_MemRead = x.emr; hz.EXMEM_MemWrite = x.emw; hz.mem_ready = x.rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_reset();
    m_mode = 0; m_waited = 0; m_stall = 0; m_flush = 0; m_to = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive('0);
    tick();
    rst = 1'b0;
    m_reset();
  endtask

  // model: mode 0 run, 1 waiting on memory, 2 dead; m_waited counts cycles already spent waiting
  function automatic logic [9:0] m_ctrl(vec_t x);
    bit memop = x.emr | x.emw;
    bit taken = (x.br & x.zf) | x.j;
    bit lu = x.imr && x.irt != 0 && (x.irt == x.rs || x.irt == x.rt);
    bit frozen = m_mode == 2 || (m_mode == 1 ? !x.rdy : memop && !x.rdy);
    logic [9:0] r = frozen ? FRZ : taken ? TKN : lu ? LUC : NRM;
    r[0] = memop && m_mode != 2;
    return r;
  endfunction

  task automatic m_step(vec_t x);
    bit memop = x.emr | x.emw;
    bit taken = (x.br & x.zf) | x.j;
    bit lu = x.imr && x.irt != 0 && (x.irt == x.rs || x.irt == x.rt);
    if (m_mode == 2) return;
    if (m_mode == 0 && memop && !x.rdy) begin
      m_mode = 1; m_waited = 0; m_stall = m_stall < MAXC ? m_stall + 1 : MAXC;
    end else if (m_mode == 1 && !x.rdy) begin
      if (m_waited == TMO - 1) begin
        m_mode = 2; m_to = 1;
      end else begin
        m_waited++; m_stall = m_stall < MAXC ? m_stall + 1 : MAXC;
      end
    end else begin
      m_mode = 0;
      if (taken) m_flush = m_flush < MAXC ? m_flush + 1 : MAXC;
      else if (lu) m_stall = m_stall < MAXC ? m_stall + 1 : MAXC;
    end
  endtask

  task automatic cyc_check();
    #3 chk("rnd ctrl", dut_ctrl(), m_ctrl(v));
    tick();
    m_step(v);
    chk("rnd state", hz.state, m_mode);
    chk("rnd stall", hz.stall_cnt, m_stall);
    chk("rnd flush", hz.flush_cnt, m_flush);
    chk("rnd tmo", hz.mem_timeout, m_to);
  endtask

  task automatic mem_wait_seq(int lows, bit jmp);
    do_reset();
    for (int i = 0; i < lows; i++) begin
      drive(mk(0, 0, 0, 0, 0, 0, jmp, 1, 0, 0));
      #3 chk("wait ctrl", dut_ctrl(), FRZ | 10'd1);
      tick();
      chk("wait state", hz.state, 1);
    end
    drive(mk(0, 0, 0, 0, 0, 0, jmp, 1, 0, 1));
    #3 chk("release ctrl", dut_ctrl(), (jmp ? TKN : NRM) | 10'd1);
    tick();
    chk("release state", hz.state, 0);
    chk("release stall", hz.stall_cnt, lows);
    chk("release flush", hz.flush_cnt, jmp);
    drive('0);
    #3 chk("after release ctrl", dut_ctrl(), NRM);
  endtask

  initial begin
    drive(mk(8, 0, 8, 1, 1, 1, 0, 1, 0, 1));
    #3 chk("rst ctrl", dut_ctrl(), 0);
    chk("rst state", hz.state, 0);
    chk("rst stall", hz.stall_cnt, 0);
    chk("rst flush", hz.flush_cnt, 0);
    chk("rst tmo", hz.mem_timeout, 0);
    tbl[0]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), NRM, 0, 0, 0};
    tbl[1]  = '{mk(8, 3, 8, 1, 0, 0, 0, 0, 0, 1), LUC, 0, 1, 0};
    tbl[2]  = '{mk(3, 8, 8, 1, 0, 0, 0, 0, 0, 1), LUC, 0, 1, 0};
    tbl[3]  = '{mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1), NRM, 0, 0, 0};
    tbl[4]  = '{mk(8, 3, 8, 0, 0, 0, 0, 0, 0, 1), NRM, 0, 0, 0};
    tbl[5]  = '{mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 1), TKN, 0, 0, 1};
    tbl[6]  = '{mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1), NRM, 0, 0, 0};
    tbl[7]  = '{mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1), TKN, 0, 0, 1};
    tbl[8]  = '{mk(8, 0, 8, 1, 1, 1, 0, 0, 0, 1), TKN, 0, 0, 1};
    tbl[9]  = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1), NRM | 10'd1, 0, 0, 0};
    tbl[10] = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), FRZ | 10'd1, 1, 1, 0};
    tbl[11] = '{mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0), FRZ | 10'd1, 1, 1, 0};
    tbl[12] = '{mk(8, 0, 8, 1, 0, 0, 0, 0, 1, 1), LUC | 10'd1, 0, 1, 0};
    tbl[13] = '{mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1), NRM, 0, 0, 0};
    tbl[14] = '{mk(1, 2, 8, 1, 0, 0, 0, 0, 0, 1), NRM, 0, 0, 0};
    for (int i = 0; i < NT; i++) begin
      do_reset();
      drive(tbl[i].in);
      #3 chk($sformatf("vec%0d ctrl", i), dut_ctrl(), tbl[i].ctrl);
      tick();
      chk($sformatf("vec%0d state", i), hz.state, tbl[i].st);
      chk($sformatf("vec%0d stall", i), hz.stall_cnt, tbl[i].stall);
      chk($sformatf("vec%0d flush", i), hz.flush_cnt, tbl[i].flush);
    end
    mem_wait_seq(3, 0);
    mem_wait_seq(3, 1);
    mem_wait_seq(0, 0);
    // timeout: one RUN stall cycle plus TMO waiting cycles, then stuck
    do_reset();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    for (int i = 1; i <= TMO + 1; i++) begin
      tick();
      chk($sformatf("tmo state c%0d", i), hz.state, i <= TMO ? 1 : 2);
    end
    chk("tmo flag", hz.mem_timeout, 1);
    chk("tmo stall", hz.stall_cnt, TMO);
    drive(mk(8, 0, 8, 1, 1, 1, 1, 1, 0, 1));
    #3 chk("error ctrl", dut_ctrl(), 0);
    tick();
    chk("error state", hz.state, 2);
    chk("error stall frozen", hz.stall_cnt, TMO);
    chk("error flush frozen", hz.flush_cnt, 0);
    #2 rst = 1'b1;
    #1 chk("tmo rst state", hz.state, 0);
    chk("tmo rst flag", hz.mem_timeout, 0);
    chk("tmo rst stall", hz.stall_cnt, 0);
    // saturation
    do_reset();
    drive(mk(8, 0, 8, 1, 0, 0, 0, 0, 0, 1));
    repeat (10) tick();
    chk("sat stall", hz.stall_cnt, MAXC);
    chk("sat state", hz.state, 0);
    // async reset between edges
    do_reset();
    drive('0);
    #3 chk("pre async ctrl", dut_ctrl(), NRM);
    rst = 1'b1;
    #1 chk("async ctrl", dut_ctrl(), 0);
    do_reset();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tick();
    tick();
    chk("mid wait state", hz.state, 1);
    #2 rst = 1'b1;
    #1 chk("mid wait rst state", hz.state, 0);
    chk("mid wait rst stall", hz.stall_cnt, 0);
    chk("mid wait rst req", hz.mem_req, 0);
    // random traffic against the model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      drive(mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
               $urandom_range(0, 3) == 0, $urandom_range(0, 1), $urandom_range(0, 7) == 0,
               $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0));
      if ($urandom_range(0, 39) == 0) begin
        #2 rst = 1'b1;
        #1 chk("rnd async ctrl", dut_ctrl(), 0);
        chk("rnd async state", hz.state, 0);
        tick();
        rst = 1'b0;
        m_reset();
      end else cyc_check();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
